xpb_sum_acc: RTL

Accumulator stage directly downstream of the xpb lookup tables in the modular-squaring reduction path. Accepts a stream of WIDTH-bit xpb values, one per accepted beat, sums them in carry-save form, then resolves the carry-save pair into a binary sum with a chunked carry-propagate adder. The result is presented on a valid/ready output for the next reduction step.

---
 rtl/xpb_sum_acc_if.sv | 27 ++
 rtl/xpb_sum_acc.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/xpb_sum_acc_if.sv
// Stream bundle between the xpb lookup tables, the sum accumulator and the
// next reduction step: a term input channel and a resolved-sum output channel.
interface xpb_sum_acc_if #(
  parameter int WIDTH = 1024,
  parameter int GUARD = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH:1]       data_in;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH+GUARD:1] data_out;
  logic                 overflow;

  // Producer of terms / consumer of sums.
  modport master (
    output in_valid, data_in, in_last, out_ready,
    input  in_ready, out_valid, data_out, overflow
  );

  // The accumulator itself.
  modport slave (
    input  in_valid, data_in, in_last, out_ready,
    output in_ready, out_valid, data_out, overflow
  );
endinterface

// File: rtl/xpb_sum_acc.sv
// Carry-save accumulator for xpb terms. Terms are summed in redundant S/C
// form at one per cycle, then the pair is resolved into a binary sum one
// CHUNK-bit slice per cycle and held until the consumer takes it.
module xpb_sum_acc #(
  parameter int WIDTH = 1024,
  parameter int GUARD = 8,
  parameter int CHUNK = 64
) (
  input logic        clk,
  input logic        reset,
  xpb_sum_acc_if.slave bus
);

  localparam int AW = WIDTH + GUARD;
  localparam int NR = (AW + CHUNK - 1) / CHUNK;
  localparam int PW = NR * CHUNK;
  localparam int KW = (NR > 1) ? $clog2(NR) : 1;
  localparam int CW = GUARD + 1;
  localparam logic [KW-1:0] K_LAST  = KW'(NR - 1);
  localparam logic [CW-1:0] CNT_SAT = CW'((1 << GUARD) + 1);

  typedef enum logic [1:0] {IDLE, ACC, RESOLVE, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   s_q, s_d;
  logic [AW-1:0]   c_q, c_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [KW-1:0]   k_q, k_d;
  logic            carry_q, carry_d;
  logic [AW-1:0]   dout_q, dout_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [WIDTH-1:0] din;
  logic [AW-1:0]    d_ext;
  logic             accept;
  logic [AW-1:0]    csa_s;
  logic [AW-1:0]    csa_c;
  logic [CW-1:0]    cnt_inc;
  logic [PW-1:0]    s_pad;
  logic [PW-1:0]    c_pad;
  logic [CHUNK:0]   chunk_sum;

  assign din    = bus.data_in;
  assign d_ext  = AW'(din);
  assign accept = bus.in_valid & in_ready_q;

  // One 3:2 compression step folds the new term into the redundant pair.
  assign csa_s = s_q ^ c_q ^ d_ext;
  assign csa_c = ((s_q & c_q) | (s_q & d_ext) | (c_q & d_ext)) << 1;

  // Term count stops at one past the guard capacity so overflow stays set.
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);

  // Zero padding lets the last, possibly partial, slice use the same adder.
  assign s_pad     = PW'(s_q);
  assign c_pad     = PW'(c_q);
  assign chunk_sum = {1'b0, s_pad[k_q*CHUNK +: CHUNK]}
                   + {1'b0, c_pad[k_q*CHUNK +: CHUNK]}
                   + (CHUNK+1)'(carry_q);

  // Next-state and datapath updates for accumulate, resolve and hand-off.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    k_d       = k_q;
    carry_d   = carry_q;
    dout_d    = dout_q;

    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          s_d     = csa_s;
          c_d     = csa_c;
          cnt_d   = cnt_inc;
          ovf_d   = ovf_q | (cnt_inc == CNT_SAT);
          state_d = bus.in_last ? RESOLVE : ACC;
          k_d     = '0;
          carry_d = 1'b0;
        end
      end
      RESOLVE: begin
        for (int b = 0; b < AW; b++) begin
          if ((b / CHUNK) == int'(k_q)) begin
            dout_d[b] = chunk_sum[b % CHUNK];
          end
        end
        carry_d = chunk_sum[CHUNK];
        k_d     = k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE) || (state_d == ACC);
    out_valid_d = (state_d == DONE);
  end

  // All state, including the handshake outputs, is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      s_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      k_q         <= '0;
      carry_q     <= 1'b0;
      dout_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      k_q         <= k_d;
      carry_q     <= carry_d;
      dout_q      <= dout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = dout_q;
  assign bus.overflow  = ovf_q;

endmodule
